// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program-counter register with a hardware call/return stack.
// Takes the next-address mux output on every enabled cycle; CALL pushes the
// return address (PC+1) and follows the mux; RET pops the saved address and
// overrides the mux. Overflow, underflow and CALL+RET set a sticky error flag.
module pc_stack_unit #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4,
   parameter int RESET_VEC   = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [ADDR_W-1:0]              PC_NextIn,
   input  logic                           PC_En,
   input  logic                           PC_Call,
   input  logic                           PC_Ret,
   output logic [ADDR_W-1:0]              PC_Out,
   output logic [$clog2(STACK_DEPTH):0]   PC_Depth,
   output logic                           PC_StackEmpty,
   output logic                           PC_StackFull,
   output logic                           PC_StackErr
);

   localparam int PTR_W = $clog2(STACK_DEPTH);
   localparam int DW    = PTR_W + 1;

   localparam logic [DW-1:0]     DEPTH_ONE = DW'(1);
   localparam logic [DW-1:0]     DEPTH_MAX = DW'(STACK_DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_VEC);

   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [DW-1:0]     depth_reg, depth_next;
   logic              err_reg, err_next;
   logic              push;

   // Small register-file stack: RET must read the top entry in the same cycle
   // so a return can follow a call with no bubble.
   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

   logic [PTR_W-1:0]  wr_idx;
   logic [PTR_W-1:0]  top_idx;
   logic [ADDR_W-1:0] ret_addr;
   logic              stack_full;
   logic              stack_empty;

   // Push slot is the current depth; top is one below (wraps harmlessly when empty).
   assign wr_idx      = depth_reg[PTR_W-1:0];
   assign top_idx     = wr_idx - PTR_ONE;
   assign ret_addr    = pc_reg + ADDR_ONE;
   assign stack_full  = (depth_reg == DEPTH_MAX);
   assign stack_empty = (depth_reg == '0);

   // Next-state decode in priority order: illegal, call, overflow, ret, underflow, plain.
   always_comb begin
      pc_next    = pc_reg;
      depth_next = depth_reg;
      err_next   = err_reg;
      push       = 1'b0;
      if (PC_En) begin
         if (PC_Call && PC_Ret) begin
            pc_next  = PC_NextIn;
            err_next = 1'b1;
         end else if (PC_Call) begin
            pc_next = PC_NextIn;
            if (!stack_full) begin
               push       = 1'b1;
               depth_next = depth_reg + DEPTH_ONE;
            end else begin
               err_next = 1'b1;
            end
         end else if (PC_Ret) begin
            if (!stack_empty) begin
               pc_next    = stack_mem[top_idx];
               depth_next = depth_reg - DEPTH_ONE;
            end else begin
               pc_next  = PC_NextIn;
               err_next = 1'b1;
            end
         end else begin
            pc_next = PC_NextIn;
         end
      end
   end

   // Control registers: PC, stack pointer and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg    <= RST_PC;
         depth_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         pc_reg    <= pc_next;
         depth_reg <= depth_next;
         err_reg   <= err_next;
      end
   end

   // Stack storage write; contents need no reset since depth gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_mem[wr_idx] <= ret_addr;
      end
   end

   assign PC_Out        = pc_reg;
   assign PC_Depth      = depth_reg;
   assign PC_StackEmpty = stack_empty;
   assign PC_StackFull  = stack_full;
   assign PC_StackErr   = err_reg;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: table-driven directed vectors, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_pc_stack_unit;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] PC_NextIn;
   logic       PC_En;
   logic       PC_Call;
   logic       PC_Ret;
   logic [7:0] PC_Out;
   logic [2:0] PC_Depth;
   logic       PC_StackEmpty;
   logic       PC_StackFull;
   logic       PC_StackErr;

   pc_stack_unit #(.ADDR_W(8), .STACK_DEPTH(DEPTH), .RESET_VEC(0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .PC_NextIn    (PC_NextIn),
      .PC_En        (PC_En),
      .PC_Call      (PC_Call),
      .PC_Ret       (PC_Ret),
      .PC_Out       (PC_Out),
      .PC_Depth     (PC_Depth),
      .PC_StackEmpty(PC_StackEmpty),
      .PC_StackFull (PC_StackFull),
      .PC_StackErr  (PC_StackErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int txn    = 0;

   // Reference model: a LIFO of return addresses, the PC and the sticky error.
   logic [7:0] m_stack [$];
   logic [7:0] m_pc;
   logic       m_err;

   function automatic void model_reset();
      m_stack.delete();
      m_pc  = 8'h00;
      m_err = 1'b0;
   endfunction

   function automatic void model_step(input logic en, input logic call, input logic ret,
                                      input logic [7:0] nin);
      if (!en) return;
      if (call && ret) begin
         m_pc  = nin;
         m_err = 1'b1;
      end else if (call) begin
         if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 8'd1);
         else                        m_err = 1'b1;
         m_pc = nin;
      end else if (ret) begin
         if (m_stack.size() > 0) m_pc = m_stack.pop_back();
         else begin
            m_pc  = nin;
            m_err = 1'b1;
         end
      end else begin
         m_pc = nin;
      end
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_exp(input string tag, input logic [7:0] pc, input int depth,
                            input logic err);
      check({tag, " pc"},    int'(PC_Out),        int'(pc));
      check({tag, " depth"}, int'(PC_Depth),      depth);
      check({tag, " empty"}, int'(PC_StackEmpty), int'(depth == 0));
      check({tag, " full"},  int'(PC_StackFull),  int'(depth == DEPTH));
      check({tag, " err"},   int'(PC_StackErr),   int'(err));
   endtask

   task automatic check_model(input string tag);
      check_exp(tag, m_pc, m_stack.size(), m_err);
   endtask

   // One enabled/stalled cycle: drive, clock, sample 1 time unit after the edge.
   task automatic step(input logic en, input logic call, input logic ret, input logic [7:0] nin);
      PC_En     = en;
      PC_Call   = call;
      PC_Ret    = ret;
      PC_NextIn = nin;
      @(posedge clk);
      #1;
      model_step(en, call, ret, nin);
      txn++;
      $display("txn %0d en=%0b call=%0b ret=%0b nin=%h -> pc=%h depth=%0d empty=%0b full=%0b err=%0b",
               txn, en, call, ret, nin, PC_Out, PC_Depth, PC_StackEmpty, PC_StackFull,
               PC_StackErr);
   endtask

   typedef struct {
      logic       en;
      logic       call;
      logic       ret;
      logic [7:0] nin;
      logic [7:0] pc;
      int         depth;
      logic       err;
   } vec_t;

   vec_t vecs [$];

   task automatic add(input logic en, input logic call, input logic ret, input logic [7:0] nin,
                      input logic [7:0] pc, input int depth, input logic err);
      vec_t v;
      v.en = en; v.call = call; v.ret = ret; v.nin = nin;
      v.pc = pc; v.depth = depth; v.err = err;
      vecs.push_back(v);
   endtask

   initial begin
      PC_En = 1'b0; PC_Call = 1'b0; PC_Ret = 1'b0; PC_NextIn = 8'h00;
      model_reset();

      // Sequential run 1..5
      for (int i = 1; i <= 5; i++) add(1, 0, 0, 8'(i), 8'(i), 0, 0);
      // Call / return
      add(1, 0, 0, 8'h10, 8'h10, 0, 0);
      add(1, 1, 0, 8'h80, 8'h80, 1, 0);
      add(1, 0, 0, 8'h81, 8'h81, 1, 0);
      add(1, 0, 0, 8'h82, 8'h82, 1, 0);
      add(1, 0, 1, 8'hFF, 8'h11, 0, 0);
      // Nested calls to full, then overflow
      add(1, 0, 0, 8'h20, 8'h20, 0, 0);
      add(1, 1, 0, 8'h30, 8'h30, 1, 0);
      add(1, 1, 0, 8'h40, 8'h40, 2, 0);
      add(1, 1, 0, 8'h50, 8'h50, 3, 0);
      add(1, 1, 0, 8'h60, 8'h60, 4, 0);
      add(1, 1, 0, 8'h90, 8'h90, 4, 1);
      add(1, 0, 1, 8'hEE, 8'h51, 3, 1);
      add(1, 0, 1, 8'hEE, 8'h41, 2, 1);
      add(1, 0, 1, 8'hEE, 8'h31, 1, 1);
      add(1, 0, 1, 8'hEE, 8'h21, 0, 1);
      // Underflow
      add(1, 0, 1, 8'h07, 8'h07, 0, 1);

      // Reset state before any clock edge
      rst_n = 1'b0;
      #2;
      check_exp("reset_init", 8'h00, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].en, vecs[i].call, vecs[i].ret, vecs[i].nin);
         check_exp($sformatf("vec%0d", i), vecs[i].pc, vecs[i].depth, vecs[i].err);
      end

      // Asynchronous reset mid-run, discarding a pending call
      PC_En = 1'b1; PC_Call = 1'b1; PC_Ret = 1'b0; PC_NextIn = 8'h99;
      #2;
      rst_n = 1'b0;
      #1;
      check_exp("async_reset", 8'h00, 0, 1'b0);
      PC_En = 1'b0; PC_Call = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_exp("after_reset", 8'h00, 0, 1'b0);

      // Illegal CALL+RET with one entry on the stack
      step(1, 1, 0, 8'h40);
      check_exp("ill_pre", 8'h40, 1, 1'b0);
      step(1, 1, 1, 8'h33);
      check_exp("illegal", 8'h33, 1, 1'b1);
      step(1, 0, 1, 8'hAA);
      check_exp("ill_ret", 8'h01, 0, 1'b1);

      // Stall with toggling controls and unknown next address
      step(1, 1, 0, 8'h55);
      check_exp("stall_pre", 8'h55, 1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(0, 1'(i), 1'(i + 1), 8'hxx);
         check_exp($sformatf("stall%0d", i), 8'h55, 1, 1'b1);
      end
      step(1, 0, 1, 8'hxx);
      check_exp("resume_ret", 8'h02, 0, 1'b1);
      step(1, 0, 0, 8'h03);
      check_exp("resume_seq", 8'h03, 0, 1'b1);

      // Back-to-back call then return
      step(1, 1, 0, 8'hC0);
      step(1, 0, 1, 8'h00);
      check_exp("b2b", 8'h04, 0, 1'b1);

      // Return-address wrap at 0xFF
      rst_n = 1'b0;
      PC_En = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1, 0, 0, 8'hFF);
      step(1, 1, 0, 8'h10);
      check_exp("wrap_call", 8'h10, 1, 1'b0);
      step(1, 0, 1, 8'h77);
      check_exp("wrap_ret", 8'h00, 0, 1'b0);

      // Randomized run against the model
      for (int i = 0; i < 400; i++) begin
         int r;
         logic en, call, ret;
         r    = $urandom_range(0, 99);
         en   = ($urandom_range(0, 9) != 0);
         call = (r < 40) || (r >= 95);
         ret  = (r >= 40 && r < 80) || (r >= 95);
         step(en, call, ret, 8'($urandom_range(0, 255)));
         check_model($sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Program-counter register with a hardware call/return stack.
- Sits directly downstream of the next-address mux. Consumes the mux output (PC+1 or jump target) every enabled cycle and drives the fetch address to program memory and the PC adder.
- Adds subroutine support: on CALL it pushes the return address and takes the mux target; on RET it pops and loads the saved address, overriding the mux.

Parameters:
- ADDR_W, 8, PC / address width in bits.
- STACK_DEPTH, 4, number of return-address entries (power of 2, min 2).
- RESET_VEC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PC_NextIn  in  ADDR_W  next address from the next-address mux.
- PC_En  in  1  advance enable; 0 = stall, all state held.
- PC_Call  in  1  from control unit: current instruction is CALL.
- PC_Ret  in  1  from control unit: current instruction is RET.
- PC_Out  out  ADDR_W  current program counter / fetch address.
- PC_Depth  out  clog2(STACK_DEPTH)+1  number of valid stack entries.
- PC_StackEmpty  out  1  PC_Depth == 0.
- PC_StackFull  out  1  PC_Depth == STACK_DEPTH.
- PC_StackErr  out  1  sticky overflow/underflow/illegal-op flag.

Behaviour:
- Clocking and reset:
  - All state updates on the rising clk edge.
  - rst_n low forces, immediately and asynchronously: PC_Out=RESET_VEC, PC_Depth=0, PC_StackEmpty=1, PC_StackFull=0, PC_StackErr=0. Stack contents are don't-care.
  - Reset mid-operation discards any in-flight call/ret.
- All outputs are registered. PC_StackEmpty and PC_StackFull are decoded from the PC_Depth register, so they change in the same cycle as PC_Depth. Latency from inputs to outputs is 1 cycle.
- Stack is a LIFO. Stack pointer = PC_Depth. Top of stack = entry[PC_Depth-1].
- Return address = (PC_Out + 1) mod 2^ADDR_W, so 0xFF wraps to 0x00 at ADDR_W=8.
- Per enabled cycle (PC_En=1), decoded in priority order:
  1. PC_Call=1 and PC_Ret=1: illegal. PC_Out<=PC_NextIn, stack unchanged, PC_StackErr<=1.
  2. PC_Call=1, stack not full: entry[PC_Depth]<=return address, PC_Depth+=1, PC_Out<=PC_NextIn.
  3. PC_Call=1, stack full: overflow. Push dropped, existing entries preserved (no overwrite), PC_Out<=PC_NextIn, PC_StackErr<=1.
  4. PC_Ret=1, stack not empty: PC_Out<=entry[PC_Depth-1], PC_Depth-=1. PC_NextIn is ignored.
  5. PC_Ret=1, stack empty: underflow. PC_Out<=PC_NextIn, PC_Depth stays 0, PC_StackErr<=1.
  6. Neither asserted: PC_Out<=PC_NextIn.
- PC_En=0: PC_Out, stack, PC_Depth and PC_StackErr all hold; PC_Call and PC_Ret are ignored.
- PC_StackErr clears only on reset.
- Back-to-back CALL/RET on consecutive enabled cycles is supported with no bubble. A RET in the cycle after a CALL returns the address just pushed.
- PC_NextIn is sampled only when PC_En=1; X on PC_NextIn during a stall or a valid RET must not propagate.
- No combinational path from any input to any output.

Test Plan:
- Reset and sequential run: assert rst_n=0 mid-run → PC_Out=0x00, Depth=0, Empty=1 immediately without a clock. Release, then drive PC_NextIn=PC_Out+1 for 5 cycles → PC_Out=0x01..0x05.
- Call/return: PC_Out=0x10, Call with NextIn=0x80 → PC_Out=0x80, Depth=1. Two plain cycles → 0x82. Ret with NextIn=0xFF → PC_Out=0x11, Depth=0, Empty=1.
- Nested calls to full: 4 calls from 0x20, 0x30, 0x40, 0x50 → Full=1, Err=0. 5th call from 0x60 to 0x90 → PC_Out=0x90, Depth=4, Err=1. 4 rets → 0x51, 0x41, 0x31, 0x21.
- Underflow and illegal op: Ret with Empty=1 and NextIn=0x07 → PC_Out=0x07, Depth=0, Err=1. After reset, Call+Ret together with NextIn=0x33 → PC_Out=0x33, Depth unchanged, Err=1.
- Stall: PC_En=0 for 3 cycles with Call/Ret toggling and PC_NextIn=X → all outputs unchanged. Re-enable → resumes from the held PC.
- Wrap: PC_Out=0xFF, Call to 0x10 → pushed 0x00. Ret → PC_Out=0x00.
